// File: rtl/loop_filter_pi.sv
// PI loop filter: two-stage integrator/proportional datapath
// with acquisition/tracking gain scheduling and a hold freeze.
module loop_filter_pi #(
  parameter int PD_W       = 30,
  parameter int OUT_W      = 32,
  parameter int ACC_W      = 40,
  parameter int KP_ACQ     = 4,
  parameter int KI_ACQ     = 10,
  parameter int KP_TRK     = 6,
  parameter int KI_TRK     = 14,
  parameter int LOCK_THR   = 4096,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pd_valid,
  input  logic signed [PD_W-1:0]  pd,
  input  logic                    hold,
  output logic signed [OUT_W-1:0] frequency_df,
  output logic                    df_valid,
  output logic                    sat,
  output logic                    locked,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    ST_ACQ   = 2'b00,
    ST_TRACK = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  localparam int SW    = ACC_W + 1;
  localparam int CNT_W = $clog2(LOCK_CNT + UNLOCK_CNT + 1);

  localparam logic [PD_W:0] THR_LO = (PD_W+1)'(LOCK_THR);
  localparam logic [PD_W:0] THR_HI = (PD_W+1)'(4 * LOCK_THR);

  localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_CNT);

  localparam logic signed [SW-1:0] OUT_MAX =
    {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] OUT_MIN =
    {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  state_t                   state_q;
  state_t                   saved_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_inc;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [PD_W-1:0]   prop_q;
  logic                     s1_valid_q;
  logic                     s1_sat_q;

  logic                     trk;
  logic                     accept;
  logic signed [PD_W-1:0]   pd_i;
  logic signed [PD_W-1:0]   pd_p;
  logic signed [SW-1:0]     acc_sum;
  logic                     acc_clamp;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [SW-1:0]     out_sum;
  logic                     out_clamp;
  logic signed [OUT_W-1:0]  out_nxt;
  logic signed [PD_W:0]     pd_ext;
  logic [PD_W:0]            pd_mag;
  logic                     pd_small;
  logic                     pd_large;

  assign state  = state_q;
  assign trk    = (state_q == ST_TRACK);
  assign accept = pd_valid && !hold && (state_q != ST_HOLD);

  assign pd_i = trk ? (pd >>> KI_TRK) : (pd >>> KI_ACQ);
  assign pd_p = trk ? (pd >>> KP_TRK) : (pd >>> KP_ACQ);

  assign acc_sum = {acc_q[ACC_W-1], acc_q}
                 + {{(SW-PD_W){pd_i[PD_W-1]}}, pd_i};
  assign acc_clamp = acc_sum[SW-1] ^ acc_sum[SW-2];
  assign acc_nxt = !acc_clamp ? acc_sum[ACC_W-1:0]
                 : (acc_sum[SW-1] ? ACC_MIN : ACC_MAX);

  assign out_sum = {acc_q[ACC_W-1], acc_q}
                 + {{(SW-PD_W){prop_q[PD_W-1]}}, prop_q};
  assign out_clamp = (out_sum > OUT_MAX) || (out_sum < OUT_MIN);

  // Output clamp to the frequency-word range
  always_comb begin
    out_nxt = out_sum[OUT_W-1:0];
    if (out_sum > OUT_MAX)
      out_nxt = OUT_MAX[OUT_W-1:0];
    else if (out_sum < OUT_MIN)
      out_nxt = OUT_MIN[OUT_W-1:0];
  end

  assign pd_ext   = {pd[PD_W-1], pd};
  assign pd_mag   = pd_ext[PD_W] ? -pd_ext : pd_ext;
  assign pd_small = (pd_mag < THR_LO);
  assign pd_large = (pd_mag >= THR_HI);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Lock FSM: run counting, hold entry/exit, registered locked flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACQ;
      saved_q <= ST_ACQ;
      cnt_q   <= '0;
      locked  <= 1'b0;
    end else if (hold) begin
      if (state_q != ST_HOLD) begin
        saved_q <= state_q;
        state_q <= ST_HOLD;
      end
    end else if (state_q == ST_HOLD) begin
      state_q <= saved_q;
      locked  <= (saved_q == ST_TRACK);
    end else if (pd_valid) begin
      case (state_q)
        ST_ACQ: begin
          if (!pd_small) begin
            cnt_q <= '0;
          end else if (cnt_inc == LOCK_N) begin
            cnt_q   <= '0;
            state_q <= ST_TRACK;
            locked  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_TRACK: begin
          if (!pd_large) begin
            cnt_q <= '0;
          end else if (cnt_inc == UNLOCK_N) begin
            cnt_q   <= '0;
            state_q <= ST_ACQ;
            locked  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  // Two-stage datapath: integrate/proportional, then sum and clamp
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      prop_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_sat_q     <= 1'b0;
      frequency_df <= '0;
      df_valid     <= 1'b0;
      sat          <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        acc_q    <= acc_nxt;
        prop_q   <= pd_p;
        s1_sat_q <= acc_clamp;
      end
      df_valid <= s1_valid_q;
      if (s1_valid_q) begin
        frequency_df <= out_nxt;
        sat          <= s1_sat_q | out_clamp;
      end
    end
  end

endmodule

// File: tb/tb_loop_filter_pi.sv
// Directed bench for loop_filter_pi with hand-computed
// expected values.
module tb_loop_filter_pi;

  logic               clk = 1'b0;
  logic               rst;
  logic               pd_valid;
  logic signed [29:0] pd;
  logic               hold;
  logic signed [31:0] frequency_df;
  logic               df_valid;
  logic               sat;
  logic               locked;
  logic [1:0]         state;

  int n_tests = 0;
  int n_fail  = 0;

  loop_filter_pi dut (
    .clk          (clk),
    .rst          (rst),
    .pd_valid     (pd_valid),
    .pd           (pd),
    .hold         (hold),
    .frequency_df (frequency_df),
    .df_valid     (df_valid),
    .sat          (sat),
    .locked       (locked),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    pd_valid = 1'b0;
    hold     = 1'b0;
    step();
    rst = 1'b0;
  endtask

  longint prev;
  int     viol;
  int     quiet_bad;

  initial begin
    rst = 1'b1; pd_valid = 1'b0; pd = '0; hold = 1'b0;
    step();
    step();
    check("rst_df", frequency_df, 0);
    check("rst_dfv", df_valid, 0);
    check("rst_sat", sat, 0);
    check("rst_locked", locked, 0);
    check("rst_state", state, 0);

    // first strobes, ACQ gains, then reset mid-stream
    rst = 1'b0; pd = 30'sd87514; pd_valid = 1'b1;
    step();
    check("lat_no_strobe", df_valid, 0);
    step();
    check("first_dfv", df_valid, 1);
    check("first_df", frequency_df, 5554);
    step();
    check("second_df", frequency_df, 5639);
    check("second_state", state, 0);
    rst = 1'b1;
    step();
    check("midrst_df", frequency_df, 0);
    check("midrst_dfv", df_valid, 0);
    check("midrst_state", state, 0);
    rst = 1'b0; pd_valid = 1'b0;
    step();
    check("midrst_discard", df_valid, 0);

    // arithmetic shift floor of -1
    pd = -30'sd1; pd_valid = 1'b1;
    step();
    pd_valid = 1'b0;
    step();
    check("neg1_dfv", df_valid, 1);
    check("neg1_df", frequency_df, -2);
    step();
    check("neg1_gap_dfv", df_valid, 0);
    check("neg1_hold_df", frequency_df, -2);

    // lock after 64 small samples with gaps
    do_reset();
    pd = 30'sd100;
    for (int i = 0; i < 64; i++) begin
      pd_valid = 1'b0;
      step();
      pd_valid = 1'b1;
      step();
      if (i == 62) check("lock_pre_state", state, 0);
    end
    check("lock_state", state, 1);
    check("lock_locked", locked, 1);
    step();
    check("lock_last_acq_df", frequency_df, 6);
    pd_valid = 1'b0;
    step();
    check("trk_gain_df", frequency_df, 1);
    step();
    check("trk_gap_dfv", df_valid, 0);
    check("trk_gap_df", frequency_df, 1);

    // hold in TRACK with in-flight drain
    pd = 30'sd1000000; pd_valid = 1'b1;
    step();
    hold = 1'b1;
    step();
    check("hold_state", state, 2);
    check("hold_locked", locked, 1);
    check("hold_drain_dfv", df_valid, 1);
    check("hold_drain_df", frequency_df, 15686);
    quiet_bad = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (df_valid !== 1'b0 || frequency_df !== 32'sd15686)
        quiet_bad++;
    end
    check("hold_quiet", quiet_bad, 0);
    check("hold_state_end", state, 2);
    hold = 1'b0;
    step();
    check("hold_release_state", state, 1);
    check("hold_release_locked", locked, 1);
    pd = '0;
    step();
    check("hold_release_nostrobe", df_valid, 0);

    // unlock: broken runs keep TRACK, 8 in a row drop to ACQ
    pd = 30'sd20000;
    for (int i = 0; i < 7; i++) step();
    pd = '0;
    step();
    pd = 30'sd20000;
    for (int i = 0; i < 7; i++) step();
    check("unlock_run7_state", state, 1);
    pd = '0;
    step();
    pd = 30'sd20000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 6) check("unlock_pre_state", state, 1);
    end
    check("unlock_state", state, 0);
    check("unlock_locked", locked, 0);
    pd_valid = 1'b0;

    // positive saturation then monotonic descent
    do_reset();
    pd = 30'sd536870911; pd_valid = 1'b1;
    for (int e = 1; e <= 4100; e++) begin
      step();
      if (e == 4033) begin
        check("sat_edge_df", frequency_df, 2147479615);
        check("sat_edge_flag", sat, 0);
      end
      if (e == 4034) begin
        check("sat_df", frequency_df, 2147483647);
        check("sat_flag", sat, 1);
      end
    end
    pd = -30'sd536870911;
    prev = frequency_df;
    viol = 0;
    for (int e = 4101; e <= 4300; e++) begin
      step();
      if (frequency_df > prev) viol++;
      prev = frequency_df;
      if (e == 4102) begin
        check("desc_first_df", frequency_df, 2115497980);
        check("desc_first_sat", sat, 0);
      end
    end
    pd_valid = 1'b0;
    step();
    if (frequency_df > prev) viol++;
    check("desc_final_df", frequency_df, 2011164668);
    check("desc_monotonic", viol, 0);
    check("desc_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_filter_pi.md
LOOP_FILTER_PI -- requirements
Module: loop_filter_pi

Interface
REQ-001 Parameters: PD_W, 30, signed phase-detector input width.
REQ-002 OUT_W, 32, signed frequency-word output width.
REQ-003 ACC_W, 40, signed integrator width; ACC_W >= OUT_W and ACC_W > PD_W.
REQ-004 KP_ACQ / KI_ACQ, 4 / 10, proportional / integral right-shift in acquisition.
REQ-005 KP_TRK / KI_TRK, 6 / 14, proportional / integral right-shift in tracking.
REQ-006 LOCK_THR, 4096, |pd| lock threshold; LOCK_CNT, 64; UNLOCK_CNT, 8.
REQ-007 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 pd_valid  in  1  pd qualifier; one sample per high cycle.
REQ-010 pd  in  PD_W  signed phase error.
REQ-011 hold  in  1  freeze loop (level).
REQ-012 frequency_df  out  OUT_W  signed NCO frequency correction.
REQ-013 df_valid  out  1  one-cycle strobe, frequency_df updated.
REQ-014 sat  out  1  clamp occurred on the sample flagged by df_valid.
REQ-015 locked  out  1  high in TRACK, and in HOLD entered from TRACK.
REQ-016 state  out  2  00 ACQ, 01 TRACK, 10 HOLD.

Function
REQ-017 Shifts SHALL be arithmetic (floor): pd=-1 yields -1 for any shift.
REQ-018 Gains SHALL follow the state at the accepting edge; TRACK uses *_TRK, otherwise *_ACQ.
REQ-019 Stage 1 (edge accepting pd_valid=1 with state != HOLD, hold=0): acc <= sat_ACC(acc + (pd>>>KI)); prop <= pd>>>KP; s1 valid.
REQ-020 Stage 2 (next edge): frequency_df <= sat_OUT(acc + prop) computed in ACC_W+1 bits; df_valid=1.
REQ-021 Latency: df_valid SHALL rise exactly 2 cycles after the pd_valid cycle; back-to-back samples every cycle SHALL be supported.
REQ-022 Saturation SHALL clamp to [-2^(W-1), 2^(W-1)-1]; no wraparound in acc or output; sat=1 if either clamp fired for that sample.
REQ-023 frequency_df SHALL hold its value between strobes.
REQ-024 |pd| SHALL be computed in PD_W+1 bits, so pd=-2^(PD_W-1) counts as large.
REQ-025 ACQ: valid sample with |pd| < LOCK_THR increments run counter, else clears it; reaching LOCK_CNT -> TRACK, counter cleared.
REQ-026 TRACK: valid sample with |pd| >= 4*LOCK_THR increments run counter, else clears it; reaching UNLOCK_CNT -> ACQ, counter cleared.
REQ-027 Cycles with pd_valid=0 SHALL leave run counters unchanged.
REQ-028 hold=1 in any state -> HOLD at next edge, previous state saved; samples ignored, acc frozen, no new stage-1 entries, counters frozen.
REQ-029 Samples already in stage 1 when hold rises SHALL complete and strobe.
REQ-030 hold=0 in HOLD -> saved state at next edge; counters resume.
REQ-031 Sample accepted on the edge causing a state change SHALL use the gains of the pre-transition state.

Reset
REQ-032 rst=1 at an edge: acc, prop, frequency_df, counters =0; df_valid, sat, locked =0; state=ACQ; pipeline valid flags cleared.
REQ-033 rst SHALL override hold and pd_valid; an in-flight sample SHALL be discarded, no strobe after reset.

Verification
REQ-034 Reset, then pd=87514 valid every cycle: first strobe frequency_df=5554 (85+5469), second 5639, state stays ACQ.
REQ-035 pd=100 for 64 valid samples (gaps with pd_valid=0 interleaved): locked=1, state=01 after 64th; next pd=100 adds 0 to acc, prop 1.
REQ-036 In TRACK: 7 samples pd=20000, one pd=0, 7 samples pd=20000 -> stays TRACK; then 8 consecutive -> ACQ, locked=0.
REQ-037 pd=536870911 continuous from reset: frequency_df saturates to 2147483647 with sat=1 (~4096 samples); then pd=-536870911 -> output falls monotonically, no wrap.
REQ-038 In TRACK, hold=1 for 10 cycles with pd=1000000 valid: state=10, locked=1, frequency_df constant, df_valid 0 after in-flight drain; hold=0 -> state=01.
REQ-039 rst=1 for one cycle mid-stream: next edge all outputs 0, state=00, no df_valid from discarded samples.
